// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   Word_t    : 32-bit bus word
//   Bit_t     : single control bit
//   ENABLE / DISABLE : control-bit constants
//   ZERO_WORD : all-zero word, returned on a timed-out access
//   BE_ALL    : full-word byte enables used by instruction fetches
//   state_e   : arbiter FSM state
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef logic [31:0] Word_t;
    typedef logic        Bit_t;

    localparam Bit_t       ENABLE    = 1'b1;
    localparam Bit_t       DISABLE   = 1'b0;
    localparam Word_t      ZERO_WORD = 32'h0000_0000;
    localparam logic [3:0] BE_ALL    = 4'b1111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// ---------------------------------------------------------------------------
// wait_timer
// Counts the cycles an access has spent waiting for bus_ack.
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset
//   clr     in  hold the count at zero (asserted while the arbiter is idle)
//   en      in  count this cycle (asserted while an access is outstanding)
//   expired out this is the last cycle the access may wait for bus_ack
// The first busy cycle sees a count of 0, so expired is raised in the
// MAX_WAIT-th busy cycle.
// ---------------------------------------------------------------------------
module wait_timer #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // The count saturates at LAST so it never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared bus.
// Data requests have strict priority. Each access is latched on grant,
// driven onto the bus until bus_ack (or a timeout), and completed with a
// one-cycle ready pulse on the requesting port.
//   clk, rst          clock, synchronous active-high reset
//   if_req/if_addr    fetch request and address
//   if_flush          drop the result of the in-flight fetch
//   if_rdata/if_ready fetch data and completion pulse
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  data request (store when dm_we=1)
//   dm_rdata/dm_ready load data and completion pulse
//   bus_req/bus_we/bus_be/bus_addr/bus_wdata  shared bus request side
//   bus_rdata/bus_ack shared bus response side
//   stall_req         pipeline stall while a request is not yet complete
//   bus_err           one-cycle pulse when an access times out
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [3:0]  dm_be,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall_req,
    output logic        bus_err
);

    state_e     state_q,    state_d;
    Bit_t       flush_q,    flush_d;
    Bit_t       we_q,       we_d;
    logic [3:0] be_q,       be_d;
    Word_t      addr_q,     addr_d;
    Word_t      wdata_q,    wdata_d;
    Word_t      if_rdata_q, if_rdata_d;
    Word_t      dm_rdata_q, dm_rdata_d;
    Bit_t       if_ready_q, if_ready_d;
    Bit_t       dm_ready_q, dm_ready_d;
    Bit_t       err_q,      err_d;

    logic busy;
    logic expired;

    assign busy = (state_q != IDLE);

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy),
        .en      (busy),
        .expired (expired)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        flush_d    = flush_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = DISABLE;
        dm_ready_d = DISABLE;
        err_d      = DISABLE;

        unique case (state_q)
            IDLE: begin
                flush_d = DISABLE;
                if (dm_req) begin
                    state_d = DM_BUSY;
                    we_d    = dm_we;
                    be_d    = dm_be;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                end else if (if_req && !if_flush) begin
                    // A flush in the grant cycle cancels the fetch outright.
                    state_d = IF_BUSY;
                    we_d    = DISABLE;
                    be_d    = BE_ALL;
                    addr_d  = if_addr;
                    wdata_d = ZERO_WORD;
                end
            end

            IF_BUSY: begin
                if (if_flush) begin
                    flush_d = ENABLE;
                end
                // A flush seen in the completing cycle counts as well.
                if (bus_ack) begin
                    state_d    = IDLE;
                    flush_d    = DISABLE;
                    if_rdata_d = bus_rdata;
                    if_ready_d = !(flush_q || if_flush);
                end else if (expired) begin
                    state_d    = IDLE;
                    flush_d    = DISABLE;
                    if_rdata_d = ZERO_WORD;
                    if_ready_d = !(flush_q || if_flush);
                    err_d      = ENABLE;
                end
            end

            DM_BUSY: begin
                // bus_ack is tested before expired so a late ack still wins.
                if (bus_ack) begin
                    state_d    = IDLE;
                    dm_ready_d = ENABLE;
                    if (!we_q) begin
                        dm_rdata_d = bus_rdata;
                    end
                end else if (expired) begin
                    state_d    = IDLE;
                    dm_ready_d = ENABLE;
                    dm_rdata_d = ZERO_WORD;
                    err_d      = ENABLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q    <= IDLE;
            flush_q    <= DISABLE;
            we_q       <= DISABLE;
            be_q       <= '0;
            addr_q     <= ZERO_WORD;
            wdata_q    <= ZERO_WORD;
            if_rdata_q <= ZERO_WORD;
            dm_rdata_q <= ZERO_WORD;
            if_ready_q <= DISABLE;
            dm_ready_q <= DISABLE;
            err_q      <= DISABLE;
        end else begin
            state_q    <= state_d;
            flush_q    <= flush_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            err_q      <= err_d;
        end
    end

    assign bus_req   = busy;
    assign bus_we    = we_q;
    assign bus_be    = be_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign bus_err   = err_q;

    assign stall_req = (dm_req && !dm_ready_q) || (if_req && !if_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed and randomized transactions against mem_arbiter (MAX_WAIT = 4).
// The bench plays both requesters and the bus slave; inputs change and
// outputs are sampled on the falling clock edge. Expected results come from
// a transaction-level model: an access answered after `delay` idle bus
// cycles completes normally when delay < MAX_WAIT, otherwise it times out.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // busy cycles without ack before the ack cycle
        int          flush_at;  // busy cycle that raises if_flush, 0 = none
    } txn_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        stall_req;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    // Model of the port data registers.
    logic [31:0] dm_rdata_m;
    logic [31:0] if_rdata_m;

    mem_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_be    (bus_be),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall_req (stall_req),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input bit is_dm, input bit we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int delay, input int flush_at);
        txn_t t;
        t.is_dm    = is_dm;
        t.we       = we;
        t.be       = be;
        t.addr     = addr;
        t.wdata    = wdata;
        t.rdata    = rdata;
        t.delay    = delay;
        t.flush_at = flush_at;
        return t;
    endfunction

    function automatic txn_t rand_txn(input bit is_dm);
        txn_t t;
        t.is_dm    = is_dm;
        t.we       = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
        t.be       = 4'($urandom_range(1, 15));
        t.addr     = $urandom();
        t.wdata    = $urandom();
        t.rdata    = $urandom();
        t.delay    = int'($urandom_range(0, MAX_WAIT + 1));
        t.flush_at = 0;
        if (!is_dm && t.delay < MAX_WAIT && $urandom_range(0, 2) == 0) begin
            t.flush_at = int'($urandom_range(1, t.delay + 1));
        end
        return t;
    endfunction

    // Present a request on its port (inputs only, no clock advance).
    task automatic issue(input txn_t t);
        if (t.is_dm) begin
            dm_req   = 1'b1;
            dm_we    = t.we;
            dm_be    = t.be;
            dm_addr  = t.addr;
            dm_wdata = t.wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = t.addr;
        end
    endtask

    // Called in the cycle the request is granted; returns in the ready cycle
    // after that port's request has been dropped.
    task automatic serve(input txn_t t, input string name);
        bit          timed_out;
        int          ack_cycle;
        bit          exp_dm_rdy;
        bit          exp_if_rdy;
        logic [36:0] exp_bus;
        logic [63:0] exp_stall;

        timed_out = (t.delay >= MAX_WAIT);
        ack_cycle = t.delay + 1;
        exp_bus   = t.is_dm ? {t.we, t.be, t.addr} : {1'b0, 4'b1111, t.addr};

        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            bus_ack   = (k == ack_cycle);
            bus_rdata = (k == ack_cycle) ? t.rdata : $urandom();
            if_flush  = (t.flush_at == k);
            check({name, " bus_req busy"}, 64'(bus_req), 64'(1'b1));
            check({name, " bus we/be/addr"}, 64'({bus_we, bus_be, bus_addr}), 64'(exp_bus));
            if (t.is_dm) begin
                check({name, " bus_wdata"}, 64'(bus_wdata), 64'(t.wdata));
            end
            check({name, " no early ready/err"}, 64'({dm_ready, if_ready, bus_err}), 64'(3'b000));
            if (k == ack_cycle) break;
        end

        @(negedge clk);
        bus_ack  = 1'b0;
        if_flush = 1'b0;

        if (t.is_dm) begin
            if (timed_out)  dm_rdata_m = 32'h0;
            else if (!t.we) dm_rdata_m = t.rdata;
            exp_dm_rdy = 1'b1;
            exp_if_rdy = 1'b0;
        end else begin
            if_rdata_m = timed_out ? 32'h0 : t.rdata;
            exp_dm_rdy = 1'b0;
            exp_if_rdy = (t.flush_at == 0);
        end
        exp_stall = 64'((dm_req && !exp_dm_rdy) || (if_req && !exp_if_rdy));

        check({name, " dm_ready"}, 64'(dm_ready), 64'(exp_dm_rdy));
        check({name, " if_ready"}, 64'(if_ready), 64'(exp_if_rdy));
        check({name, " bus_err"}, 64'(bus_err), 64'(timed_out));
        check({name, " bus_req done"}, 64'(bus_req), 64'(1'b0));
        check({name, " dm_rdata"}, 64'(dm_rdata), 64'(dm_rdata_m));
        check({name, " if_rdata"}, 64'(if_rdata), 64'(if_rdata_m));
        check({name, " stall_req"}, 64'(stall_req), exp_stall);

        if (t.is_dm) dm_req = 1'b0;
        else         if_req = 1'b0;
    endtask

    // One cycle later: pulses are over and the bus is idle.
    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, " pulses over"}, 64'({dm_ready, if_ready, bus_err}), 64'(3'b000));
        check({name, " bus idle"}, 64'(bus_req), 64'(1'b0));
    endtask

    initial begin
        txn_t t;
        txn_t t2;
        int   kind;

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        if_flush  = 1'b0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_be     = 4'h0;
        dm_addr   = 32'h0;
        dm_wdata  = 32'h0;
        bus_rdata = 32'h0;
        bus_ack   = 1'b0;
        dm_rdata_m = 32'h0;
        if_rdata_m = 32'h0;

        // Reset state: every output low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", 64'({bus_req, bus_we, bus_be, if_ready, dm_ready, bus_err, stall_req}),
              64'(10'h0));
        check("reset bus_addr", 64'(bus_addr), 64'(32'h0));
        check("reset bus_wdata", 64'(bus_wdata), 64'(32'h0));
        check("reset rdata", 64'({if_rdata, dm_rdata}), 64'(0));
        rst = 1'b0;

        // bus_ack while idle is ignored.
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        @(negedge clk);
        bus_ack = 1'b0;
        check("idle ack pulses", 64'({dm_ready, if_ready, bus_err, bus_req}), 64'(4'b0000));
        check("idle ack rdata", 64'({if_rdata, dm_rdata}), 64'(0));

        // Load, ack two cycles after bus_req.
        t = mk(1'b1, 1'b0, 4'b1111, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 2, 0);
        issue(t);
        serve(t, "load");
        idle_check("load");

        // Minimum latency: ack in the first busy cycle.
        t = mk(1'b0, 1'b0, 4'b1111, 32'h0000_0100, 32'h0, 32'hCAFE_0001, 0, 0);
        issue(t);
        serve(t, "fetch fast");
        idle_check("fetch fast");

        // Store with partial byte enables; load data register holds.
        t = mk(1'b1, 1'b1, 4'b0011, 32'h8000_0020, 32'h0000_ABCD, 32'h5555_5555, 2, 0);
        issue(t);
        serve(t, "store");
        idle_check("store");

        // Simultaneous requests: data first, fetch after one idle cycle.
        t  = mk(1'b1, 1'b1, 4'b0100, 32'h8000_0030, 32'h00AA_0000, 32'h0, 1, 0);
        t2 = mk(1'b0, 1'b0, 4'b1111, 32'h0000_0200, 32'h0, 32'h1111_2222, 1, 0);
        issue(t);
        issue(t2);
        serve(t, "prio dm");
        serve(t2, "prio if");
        idle_check("prio");

        // Flush during the fetch suppresses if_ready.
        t = mk(1'b0, 1'b0, 4'b1111, 32'h0000_0300, 32'h0, 32'h3333_4444, 2, 1);
        issue(t);
        serve(t, "flush busy");
        idle_check("flush busy");

        // Flush in the grant cycle cancels the grant; fetch proceeds afterwards.
        @(negedge clk);
        t = mk(1'b0, 1'b0, 4'b1111, 32'h0000_0400, 32'h0, 32'h7777_8888, 0, 0);
        issue(t);
        if_flush = 1'b1;
        @(negedge clk);
        check("flush cancel", 64'({bus_req, if_ready}), 64'(2'b00));
        if_flush = 1'b0;
        serve(t, "after cancel");
        idle_check("after cancel");

        // Timeout, then ack exactly on the timeout cycle.
        t = mk(1'b1, 1'b0, 4'b1111, 32'h8000_0040, 32'h0, 32'h9999_9999, MAX_WAIT, 0);
        issue(t);
        serve(t, "timeout");
        idle_check("timeout");
        t = mk(1'b1, 1'b0, 4'b1111, 32'h8000_0044, 32'h0, 32'hA5A5_5A5A, MAX_WAIT - 1, 0);
        issue(t);
        serve(t, "late ack");
        idle_check("late ack");

        // Reset one cycle after grant abandons the access.
        @(negedge clk);
        t = mk(1'b1, 1'b0, 4'b1111, 32'h8000_0050, 32'h0, 32'h0, 2, 0);
        issue(t);
        @(negedge clk);
        check("pre-reset bus_req", 64'(bus_req), 64'(1'b1));
        rst    = 1'b1;
        dm_req = 1'b0;
        @(negedge clk);
        check("mid reset ctrl", 64'({bus_req, bus_we, bus_be, dm_ready, if_ready, bus_err}), 64'(9'h0));
        check("mid reset bus", 64'({bus_addr, bus_wdata}), 64'(0));
        check("mid reset rdata", 64'({if_rdata, dm_rdata}), 64'(0));
        rst = 1'b0;
        dm_rdata_m = 32'h0;
        if_rdata_m = 32'h0;
        idle_check("after reset");

        // Randomized traffic: data only, fetch only, or both at once.
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            kind = int'($urandom_range(0, 2));
            if (kind == 2) begin
                t  = rand_txn(1'b1);
                t2 = rand_txn(1'b0);
                issue(t);
                issue(t2);
                serve(t, "rnd both dm");
                serve(t2, "rnd both if");
            end else begin
                t = rand_txn(kind == 0);
                issue(t);
                serve(t, "rnd");
            end
            idle_check("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_WAIT, default 255, meaning the maximum number of cycles to wait for bus_ack before aborting an access.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  instruction-fetch read request
- if_addr  in  32  fetch address
- if_flush  in  1  discard the in-flight fetch result
- if_rdata  out  32  fetch data
- if_ready  out  1  one-cycle fetch-complete pulse
- dm_req  in  1  data access request
- dm_we  in  1  1 = store, 0 = load
- dm_be  in  4  byte enables
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data
- dm_ready  out  1  one-cycle data-complete pulse
- bus_req  out  1  shared bus request
- bus_we  out  1  bus write enable
- bus_be  out  4  bus byte enables
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_rdata  in  32  bus read data
- bus_ack  in  1  bus completion, valid for one cycle
- stall_req  out  1  pipeline stall request
- bus_err  out  1  one-cycle timeout pulse

Function
REQ-003 The FSM SHALL have three states: IDLE, IF_BUSY and DM_BUSY.
REQ-004 In IDLE with dm_req=1, the FSM SHALL enter DM_BUSY on the next edge. dm_req has strict priority over if_req.
REQ-005 In IDLE with dm_req=0 and if_req=1, the FSM SHALL enter IF_BUSY on the next edge.
REQ-006 On grant, the FSM SHALL latch addr, we, be and wdata into registers. For fetches, bus_we=0 and bus_be=4'b1111.
REQ-007 bus_* outputs SHALL be driven from those registers and SHALL hold stable in the BUSY states until bus_ack.
REQ-008 bus_req SHALL be 1 exactly while the FSM is in IF_BUSY or DM_BUSY.
REQ-009 On bus_ack in DM_BUSY:
- dm_rdata SHALL register bus_rdata for loads, or hold its previous value for stores.
- dm_ready SHALL pulse on the next cycle.
- The FSM SHALL return to IDLE.
REQ-010 On bus_ack in IF_BUSY:
- if_rdata SHALL register bus_rdata.
- if_ready SHALL pulse on the next cycle unless a flush was recorded.
- The FSM SHALL return to IDLE.
REQ-011 if_flush=1 while in IF_BUSY SHALL set a flush flag. The bus transaction still completes, but if_ready is suppressed. The flag clears on return to IDLE.
REQ-012 if_flush=1 in IDLE on the same cycle as the IF grant SHALL cancel that grant, and the FSM SHALL stay in IDLE.
REQ-013 A wait counter SHALL count cycles spent in a BUSY state and reset on every entry into a BUSY state.
REQ-014 When the wait counter reaches MAX_WAIT without bus_ack:
- bus_err SHALL pulse for one cycle.
- The corresponding ready SHALL pulse with rdata = 32'h0.
- The FSM SHALL return to IDLE.
REQ-015 bus_ack arriving on the same cycle as the timeout SHALL take precedence; no bus_err is raised.
REQ-016 stall_req SHALL be combinational: (dm_req & ~dm_ready) | (if_req & ~if_ready).
REQ-017 Minimum latency SHALL be 3 cycles from a request in IDLE to ready: grant edge, ack cycle, ready pulse.
REQ-018 Back-to-back requests SHALL incur one IDLE cycle between accesses. A pending dm_req wins that IDLE cycle.
REQ-019 bus_ack received while in IDLE SHALL be ignored.

Reset
REQ-020 When rst=1 at a clock edge, the FSM SHALL enter IDLE, and the wait counter and flush flag SHALL clear.
REQ-021 During reset all outputs SHALL be 0, including bus_req, bus_we, bus_be, bus_addr, bus_wdata, if_rdata, dm_rdata, both ready pulses and bus_err.
REQ-022 Reset asserted mid-access SHALL abandon the access. No ready or error pulse is produced, and bus_req is low on the cycle after the reset edge.

Structure
REQ-023 The shared package SHALL hold Word_t, Bit_t, the ENABLE/DISABLE and ZERO_WORD constants, and the FSM state enum type.
REQ-024 The wait counter SHALL be a sub-module named wait_timer, with ports clr, en and expired.

Verification
REQ-025 Data load: dm_req, addr 0x80000010, with bus_ack 2 cycles after bus_req -> dm_rdata = bus_rdata 0xDEADBEEF and a single dm_ready pulse.
REQ-026 Simultaneous if_req and dm_req in IDLE -> DM access first (bus_we per dm_we), then IF access with bus_be = 4'b1111 after one IDLE cycle.
REQ-027 Store: dm_we=1, be=4'b0011, wdata 0x0000ABCD -> bus_be 4'b0011 and bus_wdata 0x0000ABCD held stable until ack.
REQ-028 if_flush during IF_BUSY, then ack -> no if_ready pulse, and the FSM is in IDLE.
REQ-029 No ack, MAX_WAIT=4 -> bus_err and dm_ready pulse together with dm_rdata 0. A second run with ack on the timeout cycle -> no bus_err.
REQ-030 rst asserted one cycle after grant -> bus_req low on the next cycle and no ready pulse.
